// File: rtl/constraint_search_ctrl_pkg.sv
// Shared definitions for the constraint search controller: FSM state
// encoding, the Galois LFSR feedback mask and the default per-check timeout.
package constraint_search_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_MASK      = 32'h80200003;
  localparam int          CHK_TO_DEFAULT = 64;

endpackage

// File: rtl/constraint_search_ctrl_cand_gen.sv
// Candidate register and next-candidate generator.
// Macro CONSTRAINT_SEARCH_LFSR_EN selects a 32-bit Galois LFSR walk (seed 0
// is replaced by 1 so the LFSR never locks up); without it the generator is a
// plain +1 sweep that wraps at 2^32 and accepts seed 0 unchanged.
module cand_gen
  import constraint_search_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] cand
);

  logic [31:0] cand_q;
  logic [31:0] cand_d;

`ifdef CONSTRAINT_SEARCH_LFSR_EN
  function automatic logic [31:0] next_cand(input logic [31:0] c);
    logic [31:0] n;
    n = c >> 1;
    if (c[0]) n = n ^ LFSR_MASK;
    return n;
  endfunction

  function automatic logic [31:0] seed_cand(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction
`else
  function automatic logic [31:0] next_cand(input logic [31:0] c);
    return c + 32'd1;
  endfunction

  function automatic logic [31:0] seed_cand(input logic [31:0] s);
    return s;
  endfunction
`endif

  // Load the seed on an accepted start, otherwise advance only when asked.
  always_comb begin
    cand_d = cand_q;
    if (load)      cand_d = seed_cand(load_val);
    else if (step) cand_d = next_cand(cand_q);
  end

  // Candidate register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cand_q <= 32'h0;
    else     cand_q <= cand_d;
  end

  assign cand = cand_q;

endmodule

// File: rtl/constraint_search_ctrl.sv
// Constraint search controller: issues candidates to an external checker one
// at a time until one is satisfied, the try limit is reached, a check times
// out, or the search is aborted.
// Optional feature: define CONSTRAINT_SEARCH_LFSR_EN for LFSR candidate order.
module constraint_search_ctrl
  import constraint_search_ctrl_pkg::*;
#(
  parameter int CHK_TO = CHK_TO_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [15:0] max_tries,
  input  logic        abort,
  output logic [31:0] cand,
  output logic        cand_valid,
  input  logic        chk_done,
  input  logic        chk_sat,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] solution,
  output logic [15:0] tries,
  output logic        timeout
);

  localparam int WCNT_W = (CHK_TO < 2) ? 1 : $clog2(CHK_TO);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(CHK_TO - 1);

  state_e            state_q, state_d;
  logic [15:0]       tries_q, tries_d;
  logic [15:0]       max_q, max_d;
  logic              found_q, found_d;
  logic [31:0]       sol_q, sol_d;
  logic              to_q, to_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              cand_load;
  logic              cand_step;

  cand_gen u_cand_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (cand_load),
    .load_val (seed),
    .step     (cand_step),
    .cand     (cand)
  );

  // Next-state and result bookkeeping. Abort outranks a same-cycle checker
  // response, and a response outranks a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    max_d     = max_q;
    found_d   = found_q;
    sol_d     = sol_q;
    to_d      = to_q;
    wcnt_d    = wcnt_q;
    cand_load = 1'b0;
    cand_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cand_load = 1'b1;
          tries_d   = 16'd0;
          max_d     = max_tries;
          found_d   = 1'b0;
          sol_d     = 32'h0;
          to_d      = 1'b0;
          wcnt_d    = '0;
          state_d   = (max_tries == 16'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        tries_d = tries_q + 16'd1;
        wcnt_d  = '0;
        state_d = abort ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (abort) begin
          state_d = S_DONE;
        end else if (chk_done) begin
          if (chk_sat) begin
            found_d = 1'b1;
            sol_d   = cand;
            state_d = S_DONE;
          end else if (tries_q < max_q) begin
            cand_step = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else if (wcnt_q == WCNT_LAST) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tries_q <= 16'd0;
      max_q   <= 16'd0;
      found_q <= 1'b0;
      sol_q   <= 32'h0;
      to_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      max_q   <= max_d;
      found_q <= found_d;
      sol_q   <= sol_d;
      to_q    <= to_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign cand_valid = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign found      = found_q;
  assign solution   = sol_q;
  assign tries      = tries_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_constraint_search_ctrl.sv
// Directed testbench for constraint_search_ctrl (CHK_TO overridden to 8).
module tb_constraint_search_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic [15:0] max_tries;
  logic        abort;
  logic [31:0] cand;
  logic        cand_valid;
  logic        chk_done;
  logic        chk_sat;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] solution;
  logic [15:0] tries;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  constraint_search_ctrl #(.CHK_TO(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .max_tries  (max_tries),
    .abort      (abort),
    .cand       (cand),
    .cand_valid (cand_valid),
    .chk_done   (chk_done),
    .chk_sat    (chk_sat),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .solution   (solution),
    .tries      (tries),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch a search: start is held for exactly one edge, leaving the DUT in
  // ISSUE (or DONE for a zero try limit).
  task automatic launch(input logic [31:0] s, input logic [15:0] m);
    seed      = s;
    max_tries = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Behaves as the checker: answers every issued candidate on its first WAIT
  // cycle, satisfied only when cand equals sat_cand (and never when never_sat).
  task automatic respond(input logic [31:0] sat_cand, input bit never_sat,
                         output int pulses);
    int cycles;
    bit pend;
    pulses = 0;
    cycles = 0;
    pend   = 1'b0;
    while (!done && cycles < 200) begin
      chk_done = 1'b0;
      chk_sat  = 1'b0;
      if (pend) begin
        chk_done = 1'b1;
        chk_sat  = !never_sat && (cand == sat_cand);
        pend     = 1'b0;
      end
      if (cand_valid) begin
        pulses++;
        pend = 1'b1;
      end
      tick();
      cycles++;
    end
    chk_done = 1'b0;
    chk_sat  = 1'b0;
    check("respond_reached_done", {31'h0, done}, 32'h1);
  endtask

  initial begin
    int pulses;
    logic [31:0] exp_first;
    logic [31:0] exp_second;

    rst       = 1'b1;
    start     = 1'b0;
    seed      = 32'h0;
    max_tries = 16'd0;
    abort     = 1'b0;
    chk_done  = 1'b0;
    chk_sat   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_cand", cand, 32'h0);
    check("rst_cand_valid", {31'h0, cand_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_found", {31'h0, found}, 32'h0);
    check("rst_solution", solution, 32'h0);
    check("rst_tries", {16'h0, tries}, 32'h0);
    check("rst_timeout", {31'h0, timeout}, 32'h0);
    rst = 1'b0;
    tick();

`ifndef CONSTRAINT_SEARCH_LFSR_EN
    // Sweep from 5, satisfied at 8
    launch(32'd5, 16'd10);
    check("s5_issue_cand", cand, 32'd5);
    check("s5_issue_valid", {31'h0, cand_valid}, 32'h1);
    check("s5_busy", {31'h0, busy}, 32'h1);
    respond(32'd8, 1'b0, pulses);
    check("s5_found", {31'h0, found}, 32'h1);
    check("s5_solution", solution, 32'd8);
    check("s5_tries", {16'h0, tries}, 32'd4);
    check("s5_pulses", pulses, 32'd4);
    tick();
    check("s5_done_one_cycle", {31'h0, done}, 32'h0);
    check("s5_idle", {31'h0, busy}, 32'h0);
    check("s5_found_held", {31'h0, found}, 32'h1);
    check("s5_solution_held", solution, 32'd8);

    // Sweep from 0, never satisfied, limit 3
    launch(32'd0, 16'd3);
    check("s0_found_cleared", {31'h0, found}, 32'h0);
    check("s0_solution_cleared", solution, 32'h0);
    check("s0_first_cand", cand, 32'h0);
    respond(32'd0, 1'b1, pulses);
    check("s0_found", {31'h0, found}, 32'h0);
    check("s0_tries", {16'h0, tries}, 32'd3);
    check("s0_pulses", pulses, 32'd3);
    tick();

    // Success on the final allowed try
    launch(32'd10, 16'd3);
    respond(32'd12, 1'b0, pulses);
    check("last_found", {31'h0, found}, 32'h1);
    check("last_solution", solution, 32'd12);
    check("last_tries", {16'h0, tries}, 32'd3);
    tick();
`endif

    // Immediate success: start, ISSUE, WAIT with response, DONE
    launch(32'd100, 16'd5);
    check("imm_issue", {31'h0, cand_valid}, 32'h1);
    tick();
    check("imm_wait_no_valid", {31'h0, cand_valid}, 32'h0);
    check("imm_wait_not_done", {31'h0, done}, 32'h0);
    chk_done = 1'b1;
    chk_sat  = 1'b1;
    tick();
    chk_done = 1'b0;
    chk_sat  = 1'b0;
    check("imm_done", {31'h0, done}, 32'h1);
    check("imm_found", {31'h0, found}, 32'h1);
    check("imm_solution", solution, 32'd100);
    check("imm_tries", {16'h0, tries}, 32'd1);
    tick();

    // Zero try limit
    launch(32'd7, 16'd0);
    check("z_done", {31'h0, done}, 32'h1);
    check("z_no_valid", {31'h0, cand_valid}, 32'h0);
    check("z_tries", {16'h0, tries}, 32'h0);
    check("z_found", {31'h0, found}, 32'h0);
    tick();
    check("z_idle", {31'h0, busy}, 32'h0);

    // Silent checker times out 8 cycles after the first WAIT cycle
    launch(32'd1, 16'd5);
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("to_not_yet", {31'h0, done}, 32'h0);
    tick();
    check("to_done", {31'h0, done}, 32'h1);
    check("to_timeout", {31'h0, timeout}, 32'h1);
    check("to_found", {31'h0, found}, 32'h0);
    tick();
    check("to_timeout_held", {31'h0, timeout}, 32'h1);

    // Abort beats a simultaneous satisfied response; start clears timeout
    launch(32'd8, 16'd5);
    check("ab_timeout_cleared", {31'h0, timeout}, 32'h0);
    tick();
    abort    = 1'b1;
    chk_done = 1'b1;
    chk_sat  = 1'b1;
    tick();
    abort    = 1'b0;
    chk_done = 1'b0;
    chk_sat  = 1'b0;
    check("ab_done", {31'h0, done}, 32'h1);
    check("ab_found", {31'h0, found}, 32'h0);
    check("ab_solution", solution, 32'h0);
    tick();

    // Response during ISSUE ignored; start while busy ignored
    launch(32'd20, 16'd5);
    chk_done = 1'b1;
    chk_sat  = 1'b1;
    tick();
    chk_done = 1'b0;
    chk_sat  = 1'b0;
    check("ign_not_done", {31'h0, done}, 32'h0);
    check("ign_found", {31'h0, found}, 32'h0);
    seed  = 32'd999;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start_cand", cand, 32'd20);
    check("ign_still_busy", {31'h0, busy}, 32'h1);
    chk_done = 1'b1;
    chk_sat  = 1'b1;
    tick();
    chk_done = 1'b0;
    chk_sat  = 1'b0;
    check("ign_found_late", {31'h0, found}, 32'h1);
    check("ign_solution", solution, 32'd20);
    tick();

    // Seed 0 candidate order for the build in use
`ifdef CONSTRAINT_SEARCH_LFSR_EN
    exp_first  = 32'h1;
    exp_second = 32'h80200003;
`else
    exp_first  = 32'h0;
    exp_second = 32'h1;
`endif
    launch(32'd0, 16'd5);
    check("seq_first", cand, exp_first);
    tick();
    chk_done = 1'b1;
    chk_sat  = 1'b0;
    tick();
    chk_done = 1'b0;
    check("seq_second", cand, exp_second);
    check("seq_reissue", {31'h0, cand_valid}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("seq_abort_done", {31'h0, done}, 32'h1);
    tick();

    // Reset mid-search discards it without a done pulse
    launch(32'd50, 16'd5);
    tick();
    rst = 1'b1;
    #1;
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_done", {31'h0, done}, 32'h0);
    check("mrst_tries", {16'h0, tries}, 32'h0);
    check("mrst_cand", cand, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("mrst_no_done", {31'h0, done}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/constraint_search_ctrl.md
CONSTRAINT_SEARCH_CTRL -- requirements
Module: constraint_search_ctrl

Interface
REQ-001 Parameter CHK_TO, default 64: cycles allowed per check before timeout.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a search; ignored unless IDLE.
REQ-005 seed  input  32  first candidate, sampled on accepted start.
REQ-006 max_tries  input  16  attempt limit, sampled on accepted start.
REQ-007 abort  input  1  terminate the current search.
REQ-008 cand  output  32  candidate assignment driven to the external constraint checker.
REQ-009 cand_valid  output  1  one-cycle pulse: cand is new and must be checked.
REQ-010 chk_done  input  1  checker response strobe.
REQ-011 chk_sat  input  1  checker verdict (all constraints satisfied), valid with chk_done.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at end of search.
REQ-014 found  output  1  result flag, held until next accepted start.
REQ-015 solution  output  32  satisfying candidate, held until next accepted start.
REQ-016 tries  output  16  candidates issued in the current/last search.
REQ-017 timeout  output  1  set when a check exceeded CHK_TO cycles, held until next accepted start.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; IDLE->ISSUE on start; ISSUE->WAIT always; WAIT->ISSUE on chk_done with chk_sat=0 and tries<max_tries; WAIT->DONE on chk_done with chk_sat=1, or tries==max_tries, or timeout; DONE->IDLE always.
REQ-019 On accepted start: cand<=seed, tries<=0, found<=0, solution<=0, timeout<=0.
REQ-020 In ISSUE: cand_valid=1 for exactly one cycle, tries increments by 1.
REQ-021 After a failing check, cand advances to the next candidate (REQ-030/031) on the WAIT->ISSUE transition.
REQ-022 chk_done with chk_sat=1: found<=1, solution<=cand, in the same edge that enters DONE.
REQ-023 chk_done outside WAIT is ignored; chk_done in the ISSUE cycle is ignored.
REQ-024 max_tries==0: IDLE->DONE directly, no cand_valid, found=0, tries=0.
REQ-025 Success on the final allowed try reports found=1, tries==max_tries.
REQ-026 Wait counter resets on each ISSUE; reaching CHK_TO in WAIT sets timeout=1, found=0, enters DONE.
REQ-027 abort in ISSUE or WAIT enters DONE next edge with found=0; abort has priority over simultaneous chk_done; abort in IDLE/DONE ignored.
REQ-028 done asserts for exactly the one cycle spent in DONE.
REQ-029 Minimum latency start->done for an immediate success: 4 cycles (IDLE, ISSUE, WAIT with chk_done, DONE).

Configuration
REQ-030 Macro CONSTRAINT_SEARCH_LFSR_EN defined: next cand is a 32-bit Galois LFSR step, shift right, XOR mask 32'h80200003 when LSB=1; seed 0 replaced by 32'h1.
REQ-031 Macro absent: next cand = cand + 1 modulo 2^32 (exhaustive sweep, 32'hFFFFFFFF wraps to 0); seed 0 used as-is.

Reset
REQ-032 On rst: state IDLE, cand=0, cand_valid=0, busy=0, done=0, found=0, solution=0, tries=0, timeout=0, wait counter=0.
REQ-033 rst mid-search discards the search with no done pulse.

Structure
REQ-034 Shared package holds the FSM state enum, LFSR mask constant and default CHK_TO.
REQ-035 Candidate generator is one sub-module, cand_gen, holding the register and both next-state functions under the macro.

Verification
REQ-036 Sweep mode, seed=5, max_tries=10, checker sat only for cand==8 -> done, found=1, solution=8, tries=4.
REQ-037 Sweep mode, seed=0, max_tries=3, checker never sat -> done, found=0, tries=3, cand_valid pulsed 3 times.
REQ-038 max_tries=0 -> done 2 cycles after start, tries=0, no cand_valid.
REQ-039 CHK_TO=8, checker silent -> timeout=1, found=0, done 8 cycles after first WAIT cycle.
REQ-040 abort asserted together with chk_done/chk_sat=1 -> found=0, done next cycle.
REQ-041 LFSR mode, seed=0 -> first cand 32'h1, second cand 32'h80200003.
